// File: rtl/pulse_seq_pkg.sv
// Shared types and helpers for the pulse sequencer: FSM states, table segment
// record, default widths and the equality comparator used for count matching.
package pulse_seq_pkg;

  localparam int SEQ_N     = 8;
  localparam int SEQ_C     = 8;
  localparam int SEQ_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [SEQ_N-1:0] period;
    logic [SEQ_C-1:0] count;
  } seg_t;

  function automatic logic eq_c(input logic [SEQ_C-1:0] a, input logic [SEQ_C-1:0] b);
    return (a == b);
  endfunction

endpackage

// File: rtl/pulse_sequencer_if.sv
// Segment write port of the pulse sequencer.
// A segment transfers on every clock edge where wr_valid & wr_ready are both high;
// the master holds wr_period/wr_count stable while wr_valid is high and not yet accepted.
interface pulse_sequencer_if
  import pulse_seq_pkg::*;
#(
  parameter int N = SEQ_N,
  parameter int C = SEQ_C
) ();
  logic         wr_valid;
  logic         wr_ready;
  logic [N-1:0] wr_period;
  logic [C-1:0] wr_count;

  modport master (output wr_valid, output wr_period, output wr_count, input wr_ready);
  modport slave  (input wr_valid, input wr_period, input wr_count, output wr_ready);
endinterface

// File: rtl/pulse_sequencer_table.sv
// Segment table: DEPTH x seg_t register file, append-only writes at index fill,
// asynchronous read by segment index, clear empties it by resetting fill.
module seq_table
  import pulse_seq_pkg::*;
#(
  parameter int DEPTH = SEQ_DEPTH,
  parameter int A     = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         we,
  input  logic         clear,
  input  seg_t         wdata,
  input  logic [A-1:0] rd_idx,
  output seg_t         rd_data,
  output logic [A:0]   fill,
  output logic         full
);

  localparam logic [A:0] DEPTH_V = (A+1)'(DEPTH);
  localparam logic [A:0] ONE_V   = (A+1)'(1);

  seg_t mem [DEPTH];

  assign full    = (fill == DEPTH_V);
  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      fill <= '0;
    end else if (clear) begin
      fill <= '0;
    end else if (we && !full) begin
      fill <= fill + ONE_V;
    end
  end

  // Contents are deliberately not reset; fill alone defines what is valid.
  always_ff @(posedge clk) begin
    if (rst && !clear && we && !full) begin
      mem[fill[A-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/pulse_sequencer.sv
// Pulse sequencer: plays a table of (period, count) segments on an external
// pulse generator, counting its pulses and advancing segment by segment.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter int N     = SEQ_N,
  parameter int C     = SEQ_C,
  parameter int DEPTH = SEQ_DEPTH,
  parameter int A     = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  pulse_sequencer_if.slave    wr,
  input  logic                clear,
  input  logic                start,
  input  logic                abort,
  output logic                pg_rst,
  output logic                pg_ena,
  output logic [N-1:0]        pg_ticks,
  input  logic                pg_pulse,
  output logic                out,
  output logic                busy,
  output logic                done,
  output logic [A-1:0]        seg_idx,
  output logic [A:0]          fill,
  output state_t              dbg_state
);

  localparam logic [A:0]   FILL_ONE = (A+1)'(1);
  localparam logic [A-1:0] IDX_ONE  = A'(1);
  localparam logic [C-1:0] CNT_ONE  = C'(1);

  state_t         state, state_n;
  logic [A-1:0]   seg_n;
  logic [C-1:0]   cnt, cnt_n, cnt_inc;
  logic [N-1:0]   ticks_n;
  logic           full, idle, we, tbl_clear, last;
  seg_t           cur;

  assign idle      = (state == S_IDLE);
  // abort outranks a write, so a write is never acknowledged in an abort cycle.
  assign wr.wr_ready = idle & ~full & ~start & ~clear & ~abort;
  assign we        = wr.wr_valid & wr.wr_ready;
  assign tbl_clear = idle & clear & ~abort;
  assign last      = ({1'b0, seg_idx} == (fill - FILL_ONE));
  assign cnt_inc   = cnt + CNT_ONE;
  assign out       = pg_pulse & pg_ena & (state == S_RUN);
  assign dbg_state = state;

  seq_table #(.DEPTH(DEPTH), .A(A)) u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .clear   (tbl_clear),
    .wdata   ('{period: wr.wr_period, count: wr.wr_count}),
    .rd_idx  (seg_idx),
    .rd_data (cur),
    .fill    (fill),
    .full    (full)
  );

  always_comb begin
    state_n = state;
    seg_n   = seg_idx;
    cnt_n   = cnt;
    ticks_n = pg_ticks;
    case (state)
      S_IDLE: begin
        if (start && !clear && (fill != '0)) begin
          state_n = S_ARM;
          seg_n   = '0;
        end
      end
      S_ARM: begin
        ticks_n = cur.period;
        cnt_n   = '0;
        if (eq_c(cur.count, '0)) begin
          if (last) begin
            state_n = S_DONE;
          end else begin
            seg_n   = seg_idx + IDX_ONE;
            state_n = S_ARM;
          end
        end else begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (pg_pulse) begin
          cnt_n = cnt_inc;
          // The pulse that reaches the count belongs to this segment.
          if (eq_c(cnt_inc, cur.count)) begin
            if (last) begin
              state_n = S_DONE;
            end else begin
              seg_n   = seg_idx + IDX_ONE;
              state_n = S_ARM;
            end
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        seg_n   = '0;
      end
      default: begin
        state_n = S_IDLE;
        seg_n   = '0;
      end
    endcase
    if (abort) begin
      state_n = S_IDLE;
      seg_n   = '0;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      seg_idx  <= '0;
      cnt      <= '0;
      pg_ticks <= '0;
      pg_rst   <= 1'b1;
      pg_ena   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      seg_idx  <= seg_n;
      cnt      <= cnt_n;
      pg_ticks <= ticks_n;
      pg_rst   <= (state_n != S_RUN);
      pg_ena   <= (state_n == S_RUN);
      done     <= (state_n == S_DONE);
      busy     <= (state_n == S_ARM) || (state_n == S_RUN);
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Bench for pulse_sequencer: table-driven write/clear/start vectors, directed
// corner sequences and randomized playback against a timeline model.
module tb_pulse_sequencer;
  import pulse_seq_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXC  = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0, start = 1'b0, abort = 1'b0;
  logic       pg_rst, pg_ena, pg_pulse, out, busy, done;
  logic [7:0] pg_ticks;
  logic [1:0] seg_idx;
  logic [2:0] fill;
  state_t     dbg_state;

  pulse_sequencer_if #(.N(8), .C(8)) bus ();

  pulse_sequencer #(.N(8), .C(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr(bus.slave), .clear(clear), .start(start), .abort(abort),
    .pg_rst(pg_rst), .pg_ena(pg_ena), .pg_ticks(pg_ticks), .pg_pulse(pg_pulse),
    .out(out), .busy(busy), .done(done), .seg_idx(seg_idx), .fill(fill), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Behavioural pulse generator: one pulse every ticks enabled cycles after restart.
  logic [7:0] g_cnt;
  logic [7:0] tm1;
  assign tm1 = pg_ticks - 8'd1;
  always_ff @(posedge clk) begin
    if (pg_rst) g_cnt <= 8'd0;
    else if (pg_ena) g_cnt <= (g_cnt == tm1) ? 8'd0 : g_cnt + 8'd1;
  end
  assign pg_pulse = pg_ena & ~pg_rst & (g_cnt == tm1);

  // ---------------- scoreboard state ----------------
  int   total = 0;
  int   bad = 0;
  seg_t model_q[$];
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic write_seg(input logic [7:0] p, input logic [7:0] c);
    bit ok = 0;
    bus.wr_valid = 1'b1; bus.wr_period = p; bus.wr_count = c;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.wr_ready) ok = 1;
      next_cycle();
    end
    bus.wr_valid = 1'b0;
    if (!ok) chk("write_timeout", 0, 1);
    else model_q.push_back('{period: p, count: c});
  endtask

  task automatic clear_tbl();
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    model_q.delete();
    chk("fill_after_clear", fill, 0);
  endtask

  // Plays the table and checks the whole timeline against the model.
  task automatic play_check(input string tag);
    logic exp_ena [MAXC];
    logic [7:0] exp_tk [MAXC];
    int t = 0;
    int T;
    for (int i = 0; i < MAXC; i++) begin exp_ena[i] = 0; exp_tk[i] = 0; end
    exp_q.delete();
    foreach (model_q[s]) begin
      int p = int'(model_q[s].period);
      int n = int'(model_q[s].count);
      t++;
      for (int r = 0; r < n * p; r++) begin
        exp_ena[t + r] = 1'b1;
        exp_tk[t + r]  = model_q[s].period;
        if ((r + 1) % p == 0) exp_q.push_back(16'(t + r));
      end
      t += n * p;
    end
    T = t;
    start = 1'b1;
    @(negedge clk);
    chk({tag, "_busy_pre"}, busy, 0);
    next_cycle();
    start = 1'b0;
    for (int c = 0; c <= T + 1; c++) begin
      @(negedge clk);
      chk({tag, "_done"}, done, (c == T) ? 1 : 0);
      chk({tag, "_busy"}, busy, (c < T) ? 1 : 0);
      chk({tag, "_ena"}, pg_ena, exp_ena[c]);
      if (exp_ena[c]) chk({tag, "_ticks"}, pg_ticks, exp_tk[c]);
      if (out) begin
        if (exp_q.size() == 0) chk({tag, "_extra_out"}, c, 32'hFFFF);
        else chk({tag, "_out_cycle"}, c, exp_q.pop_front());
      end
      next_cycle();
    end
    chk({tag, "_missing_out"}, exp_q.size(), 0);
    chk({tag, "_seg_idle"}, seg_idx, 0);
    chk({tag, "_fill_kept"}, fill, model_q.size());
  endtask

  // ---------------- IDLE vector table ----------------
  typedef struct {
    logic       valid, clr, st;
    logic [7:0] p, c;
    logic       exp_ready;
    logic [2:0] exp_fill;
  } vec_t;
  vec_t vecs[11];

  task automatic apply_vec(input int i);
    bus.wr_valid = vecs[i].valid; bus.wr_period = vecs[i].p; bus.wr_count = vecs[i].c;
    clear = vecs[i].clr; start = vecs[i].st;
    @(negedge clk);
    chk($sformatf("vec%0d_ready", i), bus.wr_ready, vecs[i].exp_ready);
    next_cycle();
    bus.wr_valid = 0; clear = 0; start = 0;
    if (vecs[i].clr) model_q.delete();
    else if (vecs[i].valid && !vecs[i].st && model_q.size() < DEPTH)
      model_q.push_back('{period: vecs[i].p, count: vecs[i].c});
    chk($sformatf("vec%0d_fill", i), fill, vecs[i].exp_fill);
    chk($sformatf("vec%0d_busy", i), busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit seen;
    bus.wr_valid = 0; bus.wr_period = 0; bus.wr_count = 0;
    vecs[0]  = '{0, 0, 0, 8'd0,  8'd0, 1, 3'd0};
    vecs[1]  = '{0, 0, 1, 8'd0,  8'd0, 0, 3'd0};
    vecs[2]  = '{1, 0, 0, 8'd3,  8'd2, 1, 3'd1};
    vecs[3]  = '{1, 0, 0, 8'd5,  8'd1, 1, 3'd2};
    vecs[4]  = '{1, 0, 0, 8'd7,  8'd1, 1, 3'd3};
    vecs[5]  = '{1, 0, 0, 8'd9,  8'd1, 1, 3'd4};
    vecs[6]  = '{1, 0, 0, 8'd11, 8'd1, 0, 3'd4};
    vecs[7]  = '{1, 1, 0, 8'd2,  8'd2, 0, 3'd0};
    vecs[8]  = '{1, 0, 0, 8'd1,  8'd1, 1, 3'd1};
    vecs[9]  = '{0, 1, 1, 8'd0,  8'd0, 0, 3'd0};
    vecs[10] = '{1, 0, 1, 8'd6,  8'd1, 0, 3'd0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pg_rst", pg_rst, 1); chk("rst_pg_ena", pg_ena, 0);
    chk("rst_ticks", pg_ticks, 0); chk("rst_done", done, 0);
    chk("rst_busy", busy, 0); chk("rst_seg", seg_idx, 0); chk("rst_fill", fill, 0);
    next_cycle();
    rst = 1'b1;

    // Fill to DEPTH, fifth write refused, then play to prove contents intact.
    for (int i = 0; i <= 6; i++) apply_vec(i);
    play_check("full4");
    for (int i = 7; i <= 10; i++) apply_vec(i);

    // Basic two-segment playback.
    clear_tbl();
    write_seg(8'd3, 8'd2); write_seg(8'd5, 8'd1);
    play_check("basic");
    chk("basic_fill", fill, 2);

    // Zero-count segment is skipped.
    clear_tbl();
    write_seg(8'd2, 8'd0); write_seg(8'd4, 8'd1);
    play_check("skip");

    // Abort mid-RUN after the first pulse, then replay from segment 0.
    clear_tbl();
    write_seg(8'd4, 8'd3);
    start = 1'b1; next_cycle(); start = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out) seen = 1;
      next_cycle();
    end
    chk("abort_first_pulse", seen, 1);
    abort = 1'b1; next_cycle(); abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0); chk("abort_ena", pg_ena, 0);
    chk("abort_pgrst", pg_rst, 1); chk("abort_done", done, 0);
    chk("abort_seg", seg_idx, 0); chk("abort_fill", fill, 1);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      @(negedge clk);
      chk("abort_no_done", done, 0);
    end
    next_cycle();
    play_check("replay");

    // Reset mid-RUN drops everything including the table.
    clear_tbl();
    write_seg(8'd3, 8'd2); write_seg(8'd5, 8'd1);
    start = 1'b1; next_cycle(); start = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b0; next_cycle();
    @(negedge clk);
    chk("mrst_pg_rst", pg_rst, 1); chk("mrst_pg_ena", pg_ena, 0);
    chk("mrst_ticks", pg_ticks, 0); chk("mrst_done", done, 0);
    chk("mrst_busy", busy, 0); chk("mrst_seg", seg_idx, 0);
    chk("mrst_fill", fill, 0); chk("mrst_out", out, 0);
    next_cycle();
    rst = 1'b1;
    model_q.delete();
    @(negedge clk);
    chk("mrst_ready", bus.wr_ready, 1);
    next_cycle();

    // Randomized tables.
    for (int it = 0; it < 8; it++) begin
      int k = $urandom_range(1, DEPTH);
      clear_tbl();
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(0, 2)) next_cycle();
        write_seg(8'($urandom_range(1, 6)), 8'($urandom_range(0, 4)));
      end
      play_check($sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
